led_effect_seq: RTL and testbench



---
 rtl/led_effect_seq.sv | 163 ++++++++++++++++
 tb/tb_led_effect_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_effect_seq.sv
// led_effect_seq: pattern sequencer feeding the 8-LED SIPO effect chain.
// Synchronises the board switches, divides clk down to a step rate and
// emits s_in / lr / step for the downstream shift register.
// Optional build macro: SW_DEBOUNCE_EN adds a per-bit switch debouncer
// (DEB_CYCLES stable cycles) between the synchroniser and mode decoding.
module led_effect_seq #(
  parameter int DIV        = 25000000,
  parameter int W          = 8,
  parameter int DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  output logic       s_in,
  output logic       lr,
  output logic       step,
  output logic [2:0] mode
);

  localparam int CW = $clog2(DIV);
  localparam int PW = $clog2(2 * W);

  localparam logic [CW-1:0] PRESC_LAST = CW'(DIV - 1);
  localparam logic [PW-1:0] POS_LAST   = PW'(2 * W - 1);
  localparam logic [PW-1:0] W_POS      = PW'(W);
  localparam logic [PW-1:0] W_LAST     = PW'(W - 1);

  typedef enum logic [2:0] {
    MODE_DOT_R   = 3'd0,
    MODE_DOT_L   = 3'd1,
    MODE_FILL_R  = 3'd2,
    MODE_FILL_L  = 3'd3,
    MODE_BOUNCE  = 3'd4,
    MODE_CHECKER = 3'd5,
    MODE_FREEZE6 = 3'd6,
    MODE_FREEZE7 = 3'd7
  } mode_e;

  if (DIV < 2 || W < 2 || DEB_CYCLES < 1) begin : g_param_check
    $error("led_effect_seq: DIV and W must be >= 2 and DEB_CYCLES >= 1");
  end

  logic [3:0]    sync1;
  logic [3:0]    sw_s;
  logic [3:0]    sw_dec;
  mode_e         mode_q, mode_d;
  logic [CW-1:0] presc_q, presc_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          s_in_q, lr_q;
  logic          s_in_d, lr_d;
  logic          mode_load;
  logic          pause;
  logic          at_wrap;
  logic          step_c;
  logic          step_mode;

  // Pattern table: returns {lr, s_in} for a mode and the position the step applies.
  function automatic logic [1:0] pattern(input mode_e m, input logic [PW-1:0] p);
    logic lo_half;
    logic dot;
    lo_half = (p < W_POS);
    dot     = (p == W_LAST) || (p == POS_LAST);
    case (m)
      MODE_DOT_R:   pattern = {1'b1, dot};
      MODE_DOT_L:   pattern = {1'b0, dot};
      MODE_FILL_R:  pattern = {1'b1, lo_half};
      MODE_FILL_L:  pattern = {1'b0, lo_half};
      MODE_BOUNCE:  pattern = {lo_half, lo_half};
      MODE_CHECKER: pattern = {1'b1, ~p[0]};
      default:      pattern = {1'b1, 1'b0};
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous board switches.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sw_s  <= '0;
    end else begin
      sync1 <= sw;
      sw_s  <= sync1;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

  logic [3:0]     sw_deb;
  logic [DCW-1:0] deb_cnt [4];

  // Per-bit debounce: accept a new level only after it has persisted unbroken.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_deb <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sw_s[i] == sw_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          sw_deb[i]  <= sw_s[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign sw_dec = sw_deb;
`else
  assign sw_dec = sw_s;
`endif

  // Next-state logic: mode load beats pause, pause beats the step strobe.
  always_comb begin
    mode_d    = mode_q;
    presc_d   = presc_q;
    pos_d     = pos_q;
    mode_load = (sw_dec[2:0] != mode_q);
    pause     = sw_dec[3];
    at_wrap   = (presc_q == PRESC_LAST);
    step_mode = (mode_q != MODE_FREEZE6) && (mode_q != MODE_FREEZE7);
    step_c    = at_wrap && !pause && !mode_load && step_mode && !reset;

    if (mode_load) begin
      mode_d  = mode_e'(sw_dec[2:0]);
      presc_d = '0;
      pos_d   = '0;
    end else if (!pause) begin
      presc_d = at_wrap ? '0 : presc_q + 1'b1;
      if (step_c) begin
        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
      end
    end

    {lr_d, s_in_d} = pattern(mode_d, pos_d);
  end

  // State and registered outputs; s_in/lr always reflect the upcoming step.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_DOT_R;
      presc_q <= '0;
      pos_q   <= '0;
      s_in_q  <= 1'b0;
      lr_q    <= 1'b1;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      pos_q   <= pos_d;
      s_in_q  <= s_in_d;
      lr_q    <= lr_d;
    end
  end

  assign s_in = s_in_q;
  assign lr   = lr_q;
  assign step = step_c;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_effect_seq.sv
// Directed self-checking bench for led_effect_seq (DIV=4, W=8, DEB_CYCLES=3).
// Define SW_DEBOUNCE_EN on both files to exercise the debounced build.
module tb_led_effect_seq;

  localparam int DIV = 4;
  localparam int W   = 8;
  localparam int DEB = 3;
`ifdef SW_DEBOUNCE_EN
  localparam int SYNC_LAT = 2 + DEB;
`else
  localparam int SYNC_LAT = 2;
`endif
  // Cycles after a prescaler wrap at which a sw edge lands on a step cycle.
  localparam int PRE_EDGE = ((3 - SYNC_LAT) % DIV + DIV) % DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       s_in, lr, step;
  logic [2:0] mode;
  logic [7:0] sipo;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  led_effect_seq #(.DIV(DIV), .W(W), .DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .s_in  (s_in),
    .lr    (lr),
    .step  (step),
    .mode  (mode)
  );

  // Downstream SIPO model: shifts on step, direction from lr.
  always @(posedge clk) begin
    if (reset)     sipo <= 8'h80;
    else if (step) sipo <= lr ? {s_in, sipo[7:1]} : {sipo[6:0], s_in};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp_s;
    reset = 1'b1;
    sw    = 4'b0000;
    repeat (3) tick();
    checks++; if (s_in !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_in: got %b want 0", s_in); end
    checks++; if (lr !== 1'b1)   begin errors++; $display("[TB] FAIL reset_lr: got %b want 1", lr); end
    checks++; if (step !== 1'b0) begin errors++; $display("[TB] FAIL reset_step: got %b want 0", step); end
    checks++; if (mode !== 3'd0) begin errors++; $display("[TB] FAIL reset_mode: got %0d want 0", mode); end
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      for (int c = 1; c <= DIV; c++) begin
        checks++;
        if (step !== 1'(c == DIV)) begin
          errors++; $display("[TB] FAIL dot_step k=%0d c=%0d: got %b want %b", k, c, step, c == DIV);
        end
        if (c == DIV) begin
          exp_s = (k == 8 || k == 16);
          checks++; if (s_in !== exp_s) begin errors++; $display("[TB] FAIL dot_s_in k=%0d: got %b want %b", k, s_in, exp_s); end
          checks++; if (lr !== 1'b1)    begin errors++; $display("[TB] FAIL dot_lr k=%0d: got %b want 1", k, lr); end
        end
        tick();
      end
    end
  endtask

  task automatic test_fill_right();
    logic exp_s;
    sw = 4'b0010;
    repeat (SYNC_LAT + 1) tick();
    checks++; if (mode !== 3'd2) begin errors++; $display("[TB] FAIL fill_mode: got %0d want 2", mode); end
    for (int k = 1; k <= 16; k++) begin
      repeat (DIV - 1) tick();
      exp_s = (k <= 8);
      checks++; if (step !== 1'b1)  begin errors++; $display("[TB] FAIL fill_step k=%0d: got %b want 1", k, step); end
      checks++; if (s_in !== exp_s) begin errors++; $display("[TB] FAIL fill_s_in k=%0d: got %b want %b", k, s_in, exp_s); end
      checks++; if (lr !== 1'b1)    begin errors++; $display("[TB] FAIL fill_lr k=%0d: got %b want 1", k, lr); end
      tick();
      if (k == 8) begin
        checks++; if (sipo !== 8'hFF) begin errors++; $display("[TB] FAIL fill_sipo8: got %b want 11111111", sipo); end
      end
      if (k == 16) begin
        checks++; if (sipo !== 8'h00) begin errors++; $display("[TB] FAIL fill_sipo16: got %b want 00000000", sipo); end
      end
    end
  endtask

  task automatic test_bounce();
    logic exp_b;
    sw = 4'b0100;
    repeat (SYNC_LAT + 1) tick();
    checks++; if (mode !== 3'd4) begin errors++; $display("[TB] FAIL bounce_mode: got %0d want 4", mode); end
    for (int k = 1; k <= 16; k++) begin
      repeat (DIV - 1) tick();
      exp_b = (k <= 8);
      checks++; if (step !== 1'b1)  begin errors++; $display("[TB] FAIL bounce_step k=%0d: got %b want 1", k, step); end
      checks++; if (s_in !== exp_b) begin errors++; $display("[TB] FAIL bounce_s_in k=%0d: got %b want %b", k, s_in, exp_b); end
      checks++; if (lr !== exp_b)   begin errors++; $display("[TB] FAIL bounce_lr k=%0d: got %b want %b", k, lr, exp_b); end
      tick();
      if (k == 8) begin
        checks++; if (sipo !== 8'hFF) begin errors++; $display("[TB] FAIL bounce_sipo8: got %b want 11111111", sipo); end
      end
      if (k == 16) begin
        checks++; if (sipo !== 8'h00) begin errors++; $display("[TB] FAIL bounce_sipo16: got %b want 00000000", sipo); end
      end
    end
  endtask

  task automatic test_mode_change();
    sw = 4'b0010;
    repeat (SYNC_LAT + 1) tick();
    checks++; if (mode !== 3'd2) begin errors++; $display("[TB] FAIL chg_start_mode: got %0d want 2", mode); end
    repeat (5 * DIV) tick();
    repeat (PRE_EDGE) tick();
    sw = 4'b0011;
    repeat (SYNC_LAT) tick();
    checks++; if (step !== 1'b0) begin errors++; $display("[TB] FAIL chg_load_step: got %b want 0", step); end
    checks++; if (mode !== 3'd2) begin errors++; $display("[TB] FAIL chg_load_mode: got %0d want 2", mode); end
    tick();
    checks++; if (mode !== 3'd3) begin errors++; $display("[TB] FAIL chg_new_mode: got %0d want 3", mode); end
    checks++; if (lr !== 1'b0)   begin errors++; $display("[TB] FAIL chg_new_lr: got %b want 0", lr); end
    checks++; if (s_in !== 1'b1) begin errors++; $display("[TB] FAIL chg_new_s_in: got %b want 1", s_in); end
    repeat (DIV - 1) tick();
    checks++; if (step !== 1'b1) begin errors++; $display("[TB] FAIL chg_first_step: got %b want 1", step); end
    checks++; if (lr !== 1'b0)   begin errors++; $display("[TB] FAIL chg_first_lr: got %b want 0", lr); end
    checks++; if (s_in !== 1'b1) begin errors++; $display("[TB] FAIL chg_first_s_in: got %b want 1", s_in); end
    tick();
  endtask

  task automatic test_pause();
    sw = 4'b0101;
    repeat (SYNC_LAT + 1) tick();
    checks++; if (mode !== 3'd5) begin errors++; $display("[TB] FAIL pause_mode: got %0d want 5", mode); end
    repeat (DIV - 1) tick();
    checks++; if (step !== 1'b1 || s_in !== 1'b1) begin
      errors++; $display("[TB] FAIL pause_pre_step: got step=%b s_in=%b want 1 1", step, s_in);
    end
    tick();
    checks++; if (s_in !== 1'b0) begin errors++; $display("[TB] FAIL pause_pos1_s_in: got %b want 0", s_in); end
    repeat (PRE_EDGE) tick();
    sw = 4'b1101;
    repeat (SYNC_LAT) tick();
    checks++; if (step !== 1'b0) begin errors++; $display("[TB] FAIL pause_wins_step: got %b want 0", step); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (step !== 1'b0 || s_in !== 1'b0 || lr !== 1'b1) begin
        errors++; $display("[TB] FAIL pause_hold i=%0d: got step=%b s_in=%b lr=%b want 0 0 1", i, step, s_in, lr);
      end
    end
    sw = 4'b0101;
    repeat (SYNC_LAT - 1) tick();
    checks++; if (step !== 1'b0) begin errors++; $display("[TB] FAIL pause_release_early: got %b want 0", step); end
    tick();
    checks++; if (step !== 1'b1) begin errors++; $display("[TB] FAIL pause_resume_step: got %b want 1", step); end
    checks++; if (s_in !== 1'b0) begin errors++; $display("[TB] FAIL pause_resume_s_in: got %b want 0", s_in); end
    tick();
    checks++; if (step !== 1'b0 || s_in !== 1'b1) begin
      errors++; $display("[TB] FAIL pause_after: got step=%b s_in=%b want 0 1", step, s_in);
    end
  endtask

  task automatic test_reset_mid();
    repeat (DIV - 1) tick();
    reset = 1'b1;
    sw    = 4'b0000;
    #1;
    checks++; if (step !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_step: got %b want 0", step); end
    tick();
    checks++; if (mode !== 3'd0 || s_in !== 1'b0 || lr !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_mid_state: got mode=%0d s_in=%b lr=%b want 0 0 1", mode, s_in, lr);
    end
    reset = 1'b0;
    repeat (DIV - 1) tick();
    checks++; if (step !== 1'b1 || s_in !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_first_step: got step=%b s_in=%b want 1 0", step, s_in);
    end
    tick();
  endtask

  task automatic test_freeze();
    sw = 4'b0110;
    repeat (SYNC_LAT + 1) tick();
    checks++; if (mode !== 3'd6 || s_in !== 1'b0 || lr !== 1'b1) begin
      errors++; $display("[TB] FAIL freeze6_state: got mode=%0d s_in=%b lr=%b want 6 0 1", mode, s_in, lr);
    end
    for (int i = 0; i < 40; i++) begin
      checks++; if (step !== 1'b0) begin errors++; $display("[TB] FAIL freeze6_step i=%0d: got %b want 0", i, step); end
      tick();
    end
    sw = 4'b0111;
    repeat (SYNC_LAT + 1) tick();
    checks++; if (mode !== 3'd7) begin errors++; $display("[TB] FAIL freeze7_mode: got %0d want 7", mode); end
    for (int i = 0; i < 40; i++) begin
      checks++; if (step !== 1'b0) begin errors++; $display("[TB] FAIL freeze7_step i=%0d: got %b want 0", i, step); end
      tick();
    end
  endtask

`ifdef SW_DEBOUNCE_EN
  task automatic test_debounce();
    sw = 4'b0000;
    repeat (SYNC_LAT + 1) tick();
    checks++; if (mode !== 3'd0) begin errors++; $display("[TB] FAIL deb_base_mode: got %0d want 0", mode); end
    sw = 4'b0001;
    repeat (2) tick();
    sw = 4'b0000;
    repeat (12) tick();
    checks++; if (mode !== 3'd0) begin errors++; $display("[TB] FAIL deb_glitch_mode: got %0d want 0", mode); end
    sw = 4'b0001;
    repeat (SYNC_LAT) tick();
    checks++; if (mode !== 3'd0) begin errors++; $display("[TB] FAIL deb_early_mode: got %0d want 0", mode); end
    tick();
    checks++; if (mode !== 3'd1) begin errors++; $display("[TB] FAIL deb_hold_mode: got %0d want 1", mode); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_right();
    test_bounce();
    test_mode_change();
    test_pause();
    test_reset_mid();
    test_freeze();
`ifdef SW_DEBOUNCE_EN
    test_debounce();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
